// File: rtl/clkdiv_n_if.sv
// clkdiv_n_if: ratio request in, divided clock / period strobe / active ratio out.
// slave  = divider side (consumes div, produces out/sync/cur)
// master = user side    (drives div, observes out/sync/cur)
interface clkdiv_n_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] div;
  logic             out;
  logic             sync;
  logic [WIDTH-1:0] cur;

  modport master (
    output div,
    input  out,
    input  sync,
    input  cur
  );

  modport slave (
    input  div,
    output out,
    output sync,
    output cur
  );
endinterface

// File: rtl/clkdiv_n.sv
// clkdiv_n: runtime-programmable integer clock divider, ratio 2 .. 2^WIDTH-1.
// A ratio of 0 or 1 parks the output low and re-samples div every cycle.
// The requested ratio is only taken at a period boundary (cnt == 0), so a
// ratio change never truncates or stretches the period in flight.
//
// Optional build macro CLKDIV_N_ODD50_EN: adds a negedge copy of the phase
// flop so odd ratios get a half-cycle-extended high phase (50% duty when the
// input clock is 50%). Without it, odd ratios are high (D-1)/2, low (D+1)/2.
module clkdiv_n #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  clkdiv_n_if.slave   bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] dl;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] last;
  logic             pe;
  logic             sync_q;
  logic             at_bound;
  logic             run_req;

  // High phase is floor(D/2) cycles; last index of the period is D-1.
  assign half     = dl >> 1;
  assign last     = dl - WIDTH'(1);
  assign at_bound = (cnt == '0);
  assign run_req  = (bus.div >= WIDTH'(2));

  // Period counter, ratio latch, posedge phase and period-start strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dl     <= '0;
      pe     <= 1'b0;
      sync_q <= 1'b0;
    end else if (at_bound) begin
      dl <= bus.div;
      if (run_req) begin
        cnt    <= WIDTH'(1);
        pe     <= 1'b1;
        sync_q <= 1'b1;
      end else begin
        cnt    <= '0;
        pe     <= 1'b0;
        sync_q <= 1'b0;
      end
    end else begin
      cnt    <= (cnt == last) ? '0 : cnt + WIDTH'(1);
      pe     <= (cnt < half);
      sync_q <= 1'b0;
    end
  end

`ifdef CLKDIV_N_ODD50_EN
  logic ne;

  // Half-cycle-delayed copy of pe; it is low again before any boundary
  // because every period ends with at least one low posedge cycle.
  always_ff @(negedge clk) begin
    if (rst) begin
      ne <= 1'b0;
    end else begin
      ne <= pe;
    end
  end

  // Odd ratios stretch the high phase by the negedge copy; even ratios use pe.
  assign bus.out = dl[0] ? (pe | ne) : pe;
`else
  // Without the negedge path the divided clock is the posedge phase flop.
  assign bus.out = pe;
`endif

  assign bus.sync = sync_q;
  assign bus.cur  = dl;

endmodule
